// File: rtl/vc16_pkg.sv
// Shared types and constants for the vc16 instruction fetch path.
package vc16_pkg;

  localparam int unsigned PARCEL_W = 16;

  // Parcel delivered in place of a faulting fetch; decode treats it as a trap.
  localparam logic [PARCEL_W-1:0] INS_TRAP = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } ifetch_state_t;

  // One prefetch queue entry: the fetched parcel and its fault flag.
  typedef struct packed {
    logic [PARCEL_W-1:0] parcel;
    logic                fault;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch queue: circular buffer with push/pop/clear and a registered head entry.
module ifetch_fifo
  import vc16_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  ifetch_entry_t          push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output ifetch_entry_t          head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ifetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;

  assign rd_nxt = rd_ptr + AW'(1);

  // Entry storage; a clear discards the write of the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Head register tracks the oldest entry so outputs never see push_data combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
    end else if (!clear) begin
      if (pop) begin
        if (count > CW'(1))  head <= mem[rd_nxt];
        else if (push)       head <= push_data;
      end else if (push && (count == '0)) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one-outstanding parcel reads, prefetch queue, PC tracking, redirect kill.
module ifetch
  import vc16_pkg::*;
#(
  parameter int unsigned   RV        = 32,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [RV-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [15:0]   ins,
  output logic          idone,
  output logic [RV-1:0] ipc,
  output logic          ifault,
  input  logic          dec_take,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic          mreq,
  output logic [RV-1:0] maddr,
  input  logic          mack,
  input  logic [15:0]   mdata,
  input  logic          mfault
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [RV-1:0] PC_STEP = RV'(2);

  ifetch_state_t st, st_next;
  logic [RV-1:0] fpc, fpc_next;
  logic [RV-1:0] hpc;
  logic [RV-1:0] rpc;
  logic          halted, halted_next;
  logic          push;
  ifetch_entry_t push_data;
  ifetch_entry_t head;
  logic [CW-1:0] count;
  logic          room_idle;
  logic          room_after;

  assign rpc    = redirect_pc & ~RV'(1);
  assign idone  = (count != '0) && dec_take && !redirect;
  assign ins    = head.parcel;
  assign ifault = head.fault;
  assign ipc    = hpc;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (idone),
    .clear     (redirect),
    .count     (count),
    .head      (head)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_next;
  end

  // Next state, queue push, next fetch PC and halt flag.
  always_comb begin
    st_next          = st;
    push             = 1'b0;
    fpc_next         = fpc;
    halted_next      = halted;
    push_data.parcel = mfault ? INS_TRAP : mdata;
    push_data.fault  = mfault;
    room_idle        = count < CW'(DEPTH);
    room_after       = (count + CW'(1) - CW'(idone)) < CW'(DEPTH);

    case (st)
      IDLE: begin
        if (redirect || (room_idle && !halted)) st_next = REQ;
      end
      REQ: begin
        if (mack) begin
          if (redirect) begin
            // Parcel belongs to the old stream; refetch starts right away.
            st_next = REQ;
          end else begin
            push     = 1'b1;
            fpc_next = fpc + PC_STEP;
            if (mfault) halted_next = 1'b1;
            st_next = (room_after && !mfault) ? REQ : IDLE;
          end
        end else if (redirect) begin
          st_next = KILL;
        end
      end
      KILL: begin
        // Stale data is dropped; the queue is empty so the new stream can start.
        if (mack) st_next = REQ;
      end
      default: st_next = IDLE;
    endcase

    if (redirect) begin
      fpc_next    = rpc;
      halted_next = 1'b0;
    end
  end

  // Fetch PC, head PC and halt flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc    <= RESET_VEC;
      hpc    <= RESET_VEC;
      halted <= 1'b0;
    end else begin
      fpc    <= fpc_next;
      halted <= halted_next;
      if (redirect)   hpc <= rpc;
      else if (idone) hpc <= hpc + PC_STEP;
    end
  end

  // Memory request port; the address is held while a killed request is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mreq  <= 1'b0;
      maddr <= RESET_VEC;
    end else begin
      mreq <= (st_next != IDLE);
      if (st_next == REQ) maddr <= fpc_next;
    end
  end

endmodule
